// File: rtl/mips_multicycle_ctrl.sv
// ============================================================================
// Module  : mips_multicycle_ctrl
// Brief   : Main control FSM for a multicycle MIPS datapath with a unified,
//           variable-latency memory port.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mips_multicycle_ctrl #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               mem_write,
    output logic               i_or_d,
    output logic               ir_write,
    output logic               pc_write,
    output logic               branch,
    output logic [1:0]         pc_src,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [2:0]         alu_control,
    output logic               reg_write,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               illegal_instr,
    output logic [STATE_W-1:0] state
);

    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_DECODE  = 4'd1;
    localparam logic [3:0] S_MEMADR  = 4'd2;
    localparam logic [3:0] S_MEMRD   = 4'd3;
    localparam logic [3:0] S_MEMWB   = 4'd4;
    localparam logic [3:0] S_MEMWR   = 4'd5;
    localparam logic [3:0] S_EXECUTE = 4'd6;
    localparam logic [3:0] S_ALUWB   = 4'd7;
    localparam logic [3:0] S_BRANCH  = 4'd8;
    localparam logic [3:0] S_ADDIEX  = 4'd9;
    localparam logic [3:0] S_ADDIWB  = 4'd10;
    localparam logic [3:0] S_JUMP    = 4'd11;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    logic [3:0] state_q;
    logic [3:0] state_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = S_FETCH;
        mem_req       = 1'b0;
        mem_write     = 1'b0;
        i_or_d        = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        branch        = 1'b0;
        pc_src        = 2'b00;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_control   = 3'b000;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        illegal_instr = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_req     = 1'b1;
                alu_src_b   = 2'b01;
                alu_control = ALU_ADD;
                ir_write    = mem_ready;
                pc_write    = mem_ready;
                state_d     = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                // Branch target precomputed here so BRANCH only needs the compare.
                alu_src_b   = 2'b11;
                alu_control = ALU_ADD;
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        state_d       = S_FETCH;
                        illegal_instr = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a   = 1'b1;
                alu_src_b   = 2'b10;
                alu_control = ALU_ADD;
                state_d     = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                i_or_d  = 1'b1;
                state_d = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                state_d   = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                state_d   = S_ALUWB;
                case (funct)
                    FN_ADD:  alu_control = ALU_ADD;
                    FN_SUB:  alu_control = ALU_SUB;
                    FN_AND:  alu_control = ALU_AND;
                    FN_OR:   alu_control = ALU_OR;
                    FN_SLT:  alu_control = ALU_SLT;
                    default: begin
                        alu_control   = ALU_ADD;
                        illegal_instr = 1'b1;
                    end
                endcase
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a   = 1'b1;
                alu_control = ALU_SUB;
                branch      = 1'b1;
                pc_src      = 2'b01;
            end
            S_ADDIEX: begin
                alu_src_a   = 1'b1;
                alu_src_b   = 2'b10;
                alu_control = ALU_ADD;
                state_d     = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write = 1'b1;
            end
            S_JUMP: begin
                pc_write = 1'b1;
                pc_src   = 2'b10;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        // Reset cycle must never leak a write enable or memory request.
        if (rst) begin
            mem_req       = 1'b0;
            mem_write     = 1'b0;
            i_or_d        = 1'b0;
            ir_write      = 1'b0;
            pc_write      = 1'b0;
            branch        = 1'b0;
            pc_src        = 2'b00;
            alu_src_a     = 1'b0;
            alu_src_b     = 2'b00;
            alu_control   = 3'b000;
            reg_write     = 1'b0;
            reg_dst       = 1'b0;
            mem_to_reg    = 1'b0;
            illegal_instr = 1'b0;
        end
    end

    assign state = STATE_W'(state_q);

endmodule

`default_nettype wire

// File: tb/tb_mips_multicycle_ctrl.sv
// ============================================================================
// Module  : tb_mips_multicycle_ctrl
// Brief   : Directed, self-checking bench for mips_multicycle_ctrl.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mips_multicycle_ctrl;

    logic       clk;
    logic       rst;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       mem_ready;
    logic       mem_req, mem_write, i_or_d, ir_write, pc_write, branch;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_control;
    logic       reg_write, reg_dst, mem_to_reg, illegal_instr;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;

    mips_multicycle_ctrl #(.STATE_W(4)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_write(mem_write), .i_or_d(i_or_d), .ir_write(ir_write),
        .pc_write(pc_write), .branch(branch), .pc_src(pc_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_control(alu_control), .reg_write(reg_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .illegal_instr(illegal_instr),
        .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {state, mem_req, mem_write, i_or_d, ir_write, pc_write, branch, pc_src,
    //  alu_src_a, alu_src_b, alu_control, reg_write, reg_dst, mem_to_reg, illegal}
    logic [21:0] obs;
    assign obs = {state, mem_req, mem_write, i_or_d, ir_write, pc_write, branch, pc_src,
                  alu_src_a, alu_src_b, alu_control, reg_write, reg_dst, mem_to_reg,
                  illegal_instr};

    localparam logic [21:0] V_ZERO    = 22'b0000_000000_00_0_00_000_0000;
    localparam logic [21:0] V_FETCH_R = 22'b0000_100110_00_0_01_010_0000;
    localparam logic [21:0] V_FETCH_W = 22'b0000_100000_00_0_01_010_0000;
    localparam logic [21:0] V_DEC     = 22'b0001_000000_00_0_11_010_0000;
    localparam logic [21:0] V_DEC_ILL = 22'b0001_000000_00_0_11_010_0001;
    localparam logic [21:0] V_MEMADR  = 22'b0010_000000_00_1_10_010_0000;
    localparam logic [21:0] V_MEMRD   = 22'b0011_101000_00_0_00_000_0000;
    localparam logic [21:0] V_RST_RD  = 22'b0011_000000_00_0_00_000_0000;
    localparam logic [21:0] V_MEMWB   = 22'b0100_000000_00_0_00_000_1010;
    localparam logic [21:0] V_MEMWR   = 22'b0101_111000_00_0_00_000_0000;
    localparam logic [21:0] V_EX_SUB  = 22'b0110_000000_00_1_00_110_0000;
    localparam logic [21:0] V_EX_SLT  = 22'b0110_000000_00_1_00_111_0000;
    localparam logic [21:0] V_EX_ILL  = 22'b0110_000000_00_1_00_010_0001;
    localparam logic [21:0] V_ALUWB   = 22'b0111_000000_00_0_00_000_1100;
    localparam logic [21:0] V_BRANCH  = 22'b1000_000001_01_1_00_110_0000;
    localparam logic [21:0] V_ADDIEX  = 22'b1001_000000_00_1_10_010_0000;
    localparam logic [21:0] V_ADDIWB  = 22'b1010_000000_00_0_00_000_1000;
    localparam logic [21:0] V_JUMP    = 22'b1011_000010_10_0_00_000_0000;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; opcode = 6'b0; funct = 6'b0; mem_ready = 1'b0;
        next_cycle();
        next_cycle();
        checks++;
        if (obs !== V_ZERO) begin
            errors++;
            $display("FAIL reset_hold: got %b expected %b", obs, V_ZERO);
        end
        mem_ready = 1'b1;
        #1;
        checks++;
        if (obs !== V_ZERO) begin
            errors++;
            $display("FAIL reset_ready_gated: got %b expected %b", obs, V_ZERO);
        end
        rst = 1'b0; mem_ready = 1'b0;
        #1;
        checks++;
        if (obs !== V_FETCH_W) begin
            errors++;
            $display("FAIL reset_release: got %b expected %b", obs, V_FETCH_W);
        end
    endtask

    task automatic test_lw();
        logic [21:0] exp [6] = '{V_FETCH_R, V_DEC, V_MEMADR, V_MEMRD, V_MEMWB, V_FETCH_W};
        logic        rdy [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        opcode = 6'b100011;
        for (int i = 0; i < 6; i++) begin
            mem_ready = rdy[i];
            #1;
            checks++;
            if (obs !== exp[i]) begin
                errors++;
                $display("FAIL lw cycle %0d: got %b expected %b", i, obs, exp[i]);
            end
            next_cycle();
        end
    endtask

    task automatic test_rtype();
        logic [5:0]  fn [3] = '{6'b100010, 6'b101010, 6'b111111};
        logic [21:0] ex [3] = '{V_EX_SUB, V_EX_SLT, V_EX_ILL};
        logic [21:0] exp [5];
        opcode = 6'b000000;
        for (int t = 0; t < 3; t++) begin
            funct = fn[t];
            exp = '{V_FETCH_R, V_DEC, ex[t], V_ALUWB, V_FETCH_W};
            for (int i = 0; i < 5; i++) begin
                mem_ready = (i == 0);
                #1;
                checks++;
                if (obs !== exp[i]) begin
                    errors++;
                    $display("FAIL rtype funct %b cycle %0d: got %b expected %b",
                             fn[t], i, obs, exp[i]);
                end
                next_cycle();
            end
        end
        funct = 6'b0;
    endtask

    task automatic test_sw_wait();
        logic [21:0] exp [8] = '{V_FETCH_R, V_DEC, V_MEMADR, V_MEMWR, V_MEMWR, V_MEMWR,
                                 V_MEMWR, V_FETCH_W};
        logic        rdy [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        opcode = 6'b101011;
        for (int i = 0; i < 8; i++) begin
            mem_ready = rdy[i];
            #1;
            checks++;
            if (obs !== exp[i]) begin
                errors++;
                $display("FAIL sw_wait cycle %0d: got %b expected %b", i, obs, exp[i]);
            end
            next_cycle();
        end
    endtask

    // mem_ready is held high through DECODE/ADDIEX/ADDIWB, where it must be ignored.
    task automatic test_fetch_wait();
        logic [21:0] exp [7] = '{V_FETCH_W, V_FETCH_W, V_FETCH_R, V_DEC, V_ADDIEX, V_ADDIWB,
                                 V_FETCH_W};
        logic        rdy [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        opcode = 6'b001000;
        for (int i = 0; i < 7; i++) begin
            mem_ready = rdy[i];
            #1;
            checks++;
            if (obs !== exp[i]) begin
                errors++;
                $display("FAIL fetch_wait_addi cycle %0d: got %b expected %b", i, obs, exp[i]);
            end
            next_cycle();
        end
    endtask

    task automatic test_branch_jump();
        logic [5:0]  ops [3] = '{6'b000100, 6'b000010, 6'b111111};
        logic [21:0] exp [3][4] = '{'{V_FETCH_R, V_DEC, V_BRANCH, V_FETCH_W},
                                    '{V_FETCH_R, V_DEC, V_JUMP, V_FETCH_W},
                                    '{V_FETCH_R, V_DEC_ILL, V_FETCH_W, V_FETCH_W}};
        for (int t = 0; t < 3; t++) begin
            opcode = ops[t];
            for (int i = 0; i < 4; i++) begin
                mem_ready = (i == 0);
                #1;
                checks++;
                if (obs !== exp[t][i]) begin
                    errors++;
                    $display("FAIL ctrl_flow op %b cycle %0d: got %b expected %b",
                             ops[t], i, obs, exp[t][i]);
                end
                next_cycle();
            end
        end
    endtask

    task automatic test_reset_midwait();
        logic [21:0] exp [11] = '{V_FETCH_R, V_DEC, V_MEMADR, V_MEMRD, V_MEMRD, V_RST_RD,
                                  V_FETCH_R, V_DEC, V_MEMADR, V_MEMRD, V_MEMWB};
        logic        rdy [11] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                                  1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic        rs  [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                                  1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        opcode = 6'b100011;
        for (int i = 0; i < 11; i++) begin
            mem_ready = rdy[i];
            rst = rs[i];
            #1;
            checks++;
            if (obs !== exp[i]) begin
                errors++;
                $display("FAIL reset_midwait cycle %0d: got %b expected %b", i, obs, exp[i]);
            end
            next_cycle();
        end
        rst = 1'b0;
        mem_ready = 1'b0;
        #1;
        checks++;
        if (obs !== V_FETCH_W) begin
            errors++;
            $display("FAIL reset_midwait end: got %b expected %b", obs, V_FETCH_W);
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_rtype();
        test_sw_wait();
        test_fetch_wait();
        test_branch_jump();
        test_reset_midwait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
Main control FSM for the multicycle MIPS datapath. It sequences the shared ALU, the unified instruction/data memory port, the PC and the register file across states for each instruction. It decodes opcode and funct from the instruction register and drives all datapath enables and muxes. The unified memory port uses a variable-latency req/ready handshake.

Parameters:
STATE_W, 4, width of the state debug output (fixed encoding, must be at least 4)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
opcode  input  6  instr[31:26] from the instruction register
funct  input  6  instr[5:0] from the instruction register
mem_ready  input  1  memory completes the current access this cycle
mem_req  output  1  memory access request
mem_write  output  1  access is a write (valid with mem_req)
i_or_d  output  1  memory address select: 0 = PC, 1 = ALUOut
ir_write  output  1  load the instruction register
pc_write  output  1  unconditional PC load
branch  output  1  PC load if ALU zero
pc_src  output  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
alu_src_a  output  1  0 = PC, 1 = register A
alu_src_b  output  2  00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left 2
alu_control  output  3  000 = AND, 001 = OR, 010 = ADD, 110 = SUB, 111 = SLT
reg_write  output  1  register file write enable
reg_dst  output  1  0 = rt, 1 = rd
mem_to_reg  output  1  0 = ALUOut, 1 = memory data
illegal_instr  output  1  one-cycle pulse on an unsupported opcode or funct
state  output  STATE_W  current state, for debug

Behaviour:
- Reset: synchronous, active-high. On the next clock edge, state becomes FETCH.
- While rst is high, every output except state is 0.
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11. Codes 12-15 return to FETCH on the next cycle, with all outputs 0.
- Outputs are Moore (a function of the current state), except that ir_write and pc_write in FETCH are gated by mem_ready. Any output not listed for a state is 0.
- FETCH: mem_req=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_control=ADD, pc_src=00, ir_write=pc_write=mem_ready. Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE: alu_src_a=0, alu_src_b=11, alu_control=ADD. Next state by opcode:
  - lw (100011) or sw (101011) -> MEMADR
  - R-type (000000) -> EXECUTE
  - beq (000100) -> BRANCH
  - addi (001000) -> ADDIEX
  - j (000010) -> JUMP
  - any other opcode -> FETCH, with illegal_instr=1 for this cycle
- MEMADR: alu_src_a=1, alu_src_b=10, ADD. Next: MEMRD if lw, MEMWR if sw.
- MEMRD: mem_req=1, i_or_d=1. Waits for mem_ready, then -> MEMWB.
- MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1. Next: FETCH.
- MEMWR: mem_req=1, mem_write=1, i_or_d=1. Waits for mem_ready, then -> FETCH.
- EXECUTE: alu_src_a=1, alu_src_b=00. alu_control by funct:
  - 100000 -> ADD, 100010 -> SUB, 100100 -> AND, 100101 -> OR, 101010 -> SLT
  - any other funct -> ADD, with illegal_instr=1
  - Next: ALUWB in all cases.
- ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0. Next: FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, SUB, branch=1, pc_src=01. Next: FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, ADD. Next: ADDIWB.
- ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0. Next: FETCH.
- JUMP: pc_write=1, pc_src=10. Next: FETCH.
- Cycle counts with zero wait states (mem_ready=1 on the first request cycle): lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- Each cycle with mem_ready=0 in a memory state adds one cycle.
- mem_req stays high and the address select stays stable until mem_ready is sampled high.
- mem_ready is ignored outside FETCH, MEMRD and MEMWR.
- rst asserted in any state, including during a memory wait, forces FETCH on the next edge. No write enable may be asserted in the reset cycle.

Test Plan:
- Reset then lw (opcode 100011) with mem_ready tied to 1 -> state sequence 0,1,2,3,4,0. reg_write=1 and mem_to_reg=1 only in state 4. ir_write and pc_write high only in the FETCH cycle.
- R-type with funct 100010 (sub), 101010 (slt) and 111111 -> alu_control 110, 111 and 010 in EXECUTE. illegal_instr pulses only for 111111. ALUWB has reg_dst=1.
- sw with mem_ready held low 3 cycles in MEMWR -> state stays 5 for 4 cycles. mem_req=mem_write=i_or_d=1 throughout. Then returns to FETCH; reg_write is never asserted.
- FETCH with mem_ready low 2 cycles -> ir_write and pc_write stay 0 until the cycle mem_ready=1. Then DECODE.
- beq and j -> states 0,1,8,0 with branch=1, pc_src=01, alu_control=110; and 0,1,11,0 with pc_write=1, pc_src=10. Unknown opcode 111111 -> 0,1,0 with illegal_instr pulsed in DECODE.
- Assert rst during a MEMRD wait -> all outputs are 0 that cycle, state=0 on the next edge, and fetch restarts normally.
